// File: rtl/cavlc_mb_scheduler_if.sv
// Signal bundle between the slice/MB parser + CAVLC decoder and the macroblock scheduler.
// The scheduler owns the slave side; a parser/decoder model or bench drives the master side.
interface cavlc_mb_scheduler_if #(
  parameter int TC_W = 5
);
  logic              MbStart;
  logic              LeftAvail;
  logic              TopAvail;
  logic [4*TC_W-1:0] LeftTotalCoeff;
  logic [4*TC_W-1:0] TopTotalCoeff;
  logic              BlockDone;
  logic [TC_W-1:0]   TotalCoeffIn;
  logic              CavlcEnable;
  logic [TC_W-1:0]   nC;
  logic [3:0]        BlkIdx;
  logic              Busy;
  logic              MbDone;
  logic              Error;
  logic [4*TC_W-1:0] RightColTC;
  logic [4*TC_W-1:0] BottomRowTC;
  logic [2:0]        DbgState;

  modport slave (
    input  MbStart, LeftAvail, TopAvail, LeftTotalCoeff, TopTotalCoeff,
           BlockDone, TotalCoeffIn,
    output CavlcEnable, nC, BlkIdx, Busy, MbDone, Error, RightColTC, BottomRowTC,
           DbgState
  );

  modport master (
    output MbStart, LeftAvail, TopAvail, LeftTotalCoeff, TopTotalCoeff,
           BlockDone, TotalCoeffIn,
    input  CavlcEnable, nC, BlkIdx, Busy, MbDone, Error, RightColTC, BottomRowTC,
           DbgState
  );
endinterface

// File: rtl/cavlc_mb_scheduler.sv
// Sequences the 16 luma 4x4 blocks of a macroblock, predicts nC from left/top TotalCoeff
// and exports the right-column / bottom-row TotalCoeff for the neighbouring macroblocks.
module cavlc_mb_scheduler #(
  parameter int TC_W    = 5,
  parameter int TIMEOUT = 1024
) (
  input logic                 Clk,
  input logic                 nReset,
  cavlc_mb_scheduler_if.slave mb
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CALC  = 3'd1;
   localparam logic [2:0] RUN   = 3'd2;
   localparam logic [2:0] STORE = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam int              WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TC_W-1:0] TC_MAX = TC_W'(16);

   logic [2:0]        state;
   logic [3:0]        blkIdx;
   logic [TC_W-1:0]   nCReg;
   logic              errorReg;
   logic              leftAvailQ;
   logic              topAvailQ;
   logic [TC_W-1:0]   leftTc [4];
   logic [TC_W-1:0]   topTc [4];
   logic [TC_W-1:0]   tc [16];
   logic [WD_W-1:0]   wdCnt;
   logic [4*TC_W-1:0] rightCol;
   logic [4*TC_W-1:0] bottomRow;

   logic [1:0]        x, y, xm1, ym1;
   logic [TC_W-1:0]   nA, nB, nCNext, tcClamped;
   logic              availA, availB, wdHit;
   logic [TC_W:0]     nSum;
   logic [4*TC_W-1:0] rightNext, bottomNext;

   // Block raster position (x, y) maps back to scan index {y1, x1, y0, x0}.
   function automatic logic [3:0] blkOf(input logic [1:0] bx, input logic [1:0] by);
      return {by[1], bx[1], by[0], bx[0]};
   endfunction

   always_comb begin
      x      = {blkIdx[2], blkIdx[0]};
      y      = {blkIdx[3], blkIdx[1]};
      xm1    = x - 2'd1;
      ym1    = y - 2'd1;
      nA     = (x != 2'd0) ? tc[blkOf(xm1, y)] : leftTc[y];
      nB     = (y != 2'd0) ? tc[blkOf(x, ym1)] : topTc[x];
      availA = (x != 2'd0) || leftAvailQ;
      availB = (y != 2'd0) || topAvailQ;
      nSum   = {1'b0, nA} + {1'b0, nB} + (TC_W+1)'(1);
      if (availA && availB) nCNext = nSum[TC_W:1];
      else if (availA)      nCNext = nA;
      else if (availB)      nCNext = nB;
      else                  nCNext = '0;
   end

   assign tcClamped = (mb.TotalCoeffIn > TC_MAX) ? TC_MAX : mb.TotalCoeffIn;

   always_comb begin
      rightNext  = '0;
      bottomNext = '0;
      for (int i = 0; i < 4; i++) begin
         rightNext[i*TC_W +: TC_W]  = tc[blkOf(2'd3, 2'(i))];
         bottomNext[i*TC_W +: TC_W] = tc[blkOf(2'(i), 2'd3)];
      end
   end

   generate
      if (TIMEOUT == 0) begin : gNoWatchdog
         assign wdHit = 1'b0;
      end else begin : gWatchdog
         assign wdHit = (wdCnt == WD_W'(TIMEOUT - 1));
      end
   endgenerate

   // Handshake: CavlcEnable is a level request held for the whole RUN state; BlockDone is
   // accepted only while CavlcEnable is high, and Enable drops the next cycle (no double count).
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state      <= IDLE;
         blkIdx     <= '0;
         nCReg      <= '0;
         errorReg   <= 1'b0;
         leftAvailQ <= 1'b0;
         topAvailQ  <= 1'b0;
         wdCnt      <= '0;
         rightCol   <= '0;
         bottomRow  <= '0;
         for (int i = 0; i < 4; i++) begin
            leftTc[i] <= '0;
            topTc[i]  <= '0;
         end
         for (int i = 0; i < 16; i++) tc[i] <= '0;
      end else begin
         case (state)
            IDLE: if (mb.MbStart) begin
               leftAvailQ <= mb.LeftAvail;
               topAvailQ  <= mb.TopAvail;
               for (int i = 0; i < 4; i++) begin
                  leftTc[i] <= mb.LeftTotalCoeff[i*TC_W +: TC_W];
                  topTc[i]  <= mb.TopTotalCoeff[i*TC_W +: TC_W];
               end
               // Cleared so an aborted macroblock exports 0 for undecoded blocks.
               for (int i = 0; i < 16; i++) tc[i] <= '0;
               blkIdx   <= '0;
               errorReg <= 1'b0;
               state    <= CALC;
            end
            CALC: begin
               nCReg <= nCNext;
               wdCnt <= '0;
               state <= RUN;
            end
            RUN: begin
               if (mb.BlockDone) begin
                  tc[blkIdx] <= tcClamped;
                  state      <= STORE;
               end else if (wdHit) begin
                  errorReg  <= 1'b1;
                  rightCol  <= rightNext;
                  bottomRow <= bottomNext;
                  state     <= DONE;
               end else begin
                  wdCnt <= wdCnt + WD_W'(1);
               end
            end
            STORE: begin
               if (blkIdx == 4'd15) begin
                  rightCol  <= rightNext;
                  bottomRow <= bottomNext;
                  state     <= DONE;
               end else begin
                  blkIdx <= blkIdx + 4'd1;
                  state  <= CALC;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign mb.CavlcEnable = (state == RUN);
   assign mb.nC          = nCReg;
   assign mb.BlkIdx      = blkIdx;
   assign mb.Busy        = (state != IDLE);
   assign mb.MbDone      = (state == DONE);
   assign mb.Error       = errorReg;
   assign mb.RightColTC  = rightCol;
   assign mb.BottomRowTC = bottomRow;
   assign mb.DbgState    = state;

endmodule

// File: tb/tb_cavlc_mb_scheduler.sv
// Bench for cavlc_mb_scheduler: a per-macroblock plan feeds a behavioural nC/TC model whose
// expected (block, nC) stream is checked by a free-running compare process.
module tb_cavlc_mb_scheduler;

   localparam int TC_W    = 5;
   localparam int TIMEOUT = 8;
   localparam int W       = 4 + TC_W;

   logic Clk    = 1'b0;
   logic nReset = 1'b0;
   always #5 Clk = ~Clk;

   cavlc_mb_scheduler_if #(.TC_W(TC_W)) mbIf ();
   cavlc_mb_scheduler #(.TC_W(TC_W), .TIMEOUT(TIMEOUT)) dut (
      .Clk    (Clk),
      .nReset (nReset),
      .mb     (mbIf)
   );

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] exp_q[$];

   // Model state for the macroblock currently being driven
   bit mLa, mTa;
   int mLv[4], mTv[4];
   int tcPlan[16];
   int litNc[16];
   int litExp;
   int mTc[4][4];
   logic [4*TC_W-1:0] expRight, expBottom;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int bx(input int b); return ((b >> 2) & 1) * 2 + (b & 1); endfunction
   function automatic int by(input int b); return ((b >> 3) & 1) * 2 + ((b >> 1) & 1); endfunction

   function automatic int modelNc(input int b);
      int x, y, a, t;
      bit hasA, hasB;
      x = bx(b);
      y = by(b);
      hasA = (x > 0) || mLa;
      hasB = (y > 0) || mTa;
      a = (x > 0) ? mTc[x-1][y] : mLv[y];
      t = (y > 0) ? mTc[x][y-1] : mTv[x];
      if (hasA && hasB) return (a + t + 1) / 2;
      if (hasA) return a;
      if (hasB) return t;
      return 0;
   endfunction

   // Compare process: each RUN entry pops one expectation, held stable through RUN.
   logic         prevEn = 1'b0;
   logic [W-1:0] curExp = '0;
   always @(negedge Clk) begin
      if (mbIf.CavlcEnable) begin
         if (!prevEn) begin
            if (exp_q.size() == 0) check("unexpected_run", 32'd1, 32'd0);
            else curExp = exp_q.pop_front();
         end
         check("run_blkidx", 32'(mbIf.BlkIdx), 32'(curExp[W-1:TC_W]));
         check("run_nc", 32'(mbIf.nC), 32'(curExp[TC_W-1:0]));
      end
      prevEn = mbIf.CavlcEnable;
   end

   task automatic checkExports();
      logic [4*TC_W-1:0] lit;
      check("right_col_tc", 32'(mbIf.RightColTC), 32'(expRight));
      check("bottom_row_tc", 32'(mbIf.BottomRowTC), 32'(expBottom));
      if (litExp >= 0) begin
         for (int i = 0; i < 4; i++) lit[i*TC_W +: TC_W] = TC_W'(litExp);
         check("right_col_lit", 32'(mbIf.RightColTC), 32'(lit));
         check("bottom_row_lit", 32'(mbIf.BottomRowTC), 32'(lit));
      end
   endtask

   task automatic clearPins();
      for (int b = 0; b < 16; b++) litNc[b] = -1;
      litExp = -1;
   endtask

   task automatic randomizeMb();
      mLa = 1'($urandom_range(0, 1));
      mTa = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
         mLv[i] = $urandom_range(0, 16);
         mTv[i] = $urandom_range(0, 16);
      end
      for (int b = 0; b < 16; b++) tcPlan[b] = $urandom_range(0, 20);
      clearPins();
   endtask

   // Runs one macroblock. toBlk: block left without BlockDone; glitchBlk: MbStart pulsed
   // during that block's RUN (16 = during DONE); rstBlk: nReset pulsed in that block's RUN.
   task automatic runMb(input int toBlk, input int glitchBlk, input int rstBlk, input int fixDelay);
      int used, d, runCycles;
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) mTc[i][j] = 0;
      for (int b = 0; b < 16; b++) begin
         exp_q.push_back({4'(b), TC_W'(modelNc(b))});
         if (b == toBlk || b == rstBlk) break;
         mTc[bx(b)][by(b)] = (tcPlan[b] > 16) ? 16 : tcPlan[b];
      end
      for (int i = 0; i < 4; i++) begin
         expRight[i*TC_W +: TC_W]  = TC_W'(mTc[3][i]);
         expBottom[i*TC_W +: TC_W] = TC_W'(mTc[i][3]);
      end

      @(negedge Clk);
      mbIf.MbStart   = 1'b1;
      mbIf.LeftAvail = mLa;
      mbIf.TopAvail  = mTa;
      for (int i = 0; i < 4; i++) begin
         mbIf.LeftTotalCoeff[i*TC_W +: TC_W] = TC_W'(mLv[i]);
         mbIf.TopTotalCoeff[i*TC_W +: TC_W]  = TC_W'(mTv[i]);
      end
      @(negedge Clk);
      mbIf.MbStart = 1'b0;
      check("start_busy", 32'(mbIf.Busy), 32'd1);
      check("start_enable_low", 32'(mbIf.CavlcEnable), 32'd0);
      check("start_error_cleared", 32'(mbIf.Error), 32'd0);
      @(negedge Clk);
      check("start_latency", 32'(mbIf.CavlcEnable), 32'd1);

      for (int b = 0; b < 16; b++) begin
         if (litNc[b] >= 0) check("lit_nc", 32'(mbIf.nC), 32'(litNc[b]));
         if (b == rstBlk) begin
            #2 nReset = 1'b0;
            #1;
            check("rst_enable", 32'(mbIf.CavlcEnable), 32'd0);
            check("rst_busy", 32'(mbIf.Busy), 32'd0);
            check("rst_nc", 32'(mbIf.nC), 32'd0);
            check("rst_blkidx", 32'(mbIf.BlkIdx), 32'd0);
            check("rst_mbdone", 32'(mbIf.MbDone), 32'd0);
            check("rst_error", 32'(mbIf.Error), 32'd0);
            check("rst_right", 32'(mbIf.RightColTC), 32'd0);
            check("rst_bottom", 32'(mbIf.BottomRowTC), 32'd0);
            @(negedge Clk);
            nReset = 1'b1;
            exp_q.delete();
            return;
         end
         used = 0;
         if (b == glitchBlk) begin
            mbIf.MbStart = 1'b1;
            @(negedge Clk);
            mbIf.MbStart = 1'b0;
            used = 1;
         end
         if (b == toBlk) begin
            runCycles = 1 + used;
            for (int k = 0; k < 40; k++) begin
               @(negedge Clk);
               if (!mbIf.CavlcEnable) break;
               runCycles++;
            end
            check("timeout_run_cycles", 32'(runCycles), 32'(TIMEOUT));
            check("timeout_mbdone", 32'(mbIf.MbDone), 32'd1);
            check("timeout_error", 32'(mbIf.Error), 32'd1);
            checkExports();
            @(negedge Clk);
            check("timeout_idle", 32'(mbIf.Busy), 32'd0);
            check("error_sticky", 32'(mbIf.Error), 32'd1);
            check("queue_empty", 32'(exp_q.size()), 32'd0);
            return;
         end
         d = (fixDelay >= 0) ? fixDelay : $urandom_range(0, TIMEOUT - 1 - used);
         repeat (d) @(negedge Clk);
         mbIf.BlockDone    = 1'b1;
         mbIf.TotalCoeffIn = TC_W'(tcPlan[b]);
         @(posedge Clk);
         #1 mbIf.BlockDone = 1'b0;
         @(negedge Clk);
         check("done_gap1", 32'(mbIf.CavlcEnable), 32'd0);
         if (b < 15) begin
            @(negedge Clk);
            check("done_gap2", 32'(mbIf.CavlcEnable), 32'd0);
            @(negedge Clk);
            check("reenable", 32'(mbIf.CavlcEnable), 32'd1);
         end else begin
            @(negedge Clk);
            check("mbdone_pulse", 32'(mbIf.MbDone), 32'd1);
            check("mbdone_busy", 32'(mbIf.Busy), 32'd1);
            check("mbdone_error", 32'(mbIf.Error), 32'd0);
            checkExports();
            if (glitchBlk == 16) mbIf.MbStart = 1'b1;
            @(negedge Clk);
            mbIf.MbStart = 1'b0;
            check("mbdone_single", 32'(mbIf.MbDone), 32'd0);
            check("idle_after_done", 32'(mbIf.Busy), 32'd0);
         end
      end
      check("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      mbIf.MbStart        = 1'b0;
      mbIf.LeftAvail      = 1'b0;
      mbIf.TopAvail       = 1'b0;
      mbIf.LeftTotalCoeff = '0;
      mbIf.TopTotalCoeff  = '0;
      mbIf.BlockDone      = 1'b0;
      mbIf.TotalCoeffIn   = '0;

      // Reset state
      repeat (3) @(negedge Clk);
      check("reset_enable", 32'(mbIf.CavlcEnable), 32'd0);
      check("reset_busy", 32'(mbIf.Busy), 32'd0);
      check("reset_nc", 32'(mbIf.nC), 32'd0);
      check("reset_blkidx", 32'(mbIf.BlkIdx), 32'd0);
      check("reset_mbdone", 32'(mbIf.MbDone), 32'd0);
      check("reset_error", 32'(mbIf.Error), 32'd0);
      check("reset_right", 32'(mbIf.RightColTC), 32'd0);
      check("reset_bottom", 32'(mbIf.BottomRowTC), 32'd0);
      nReset = 1'b1;
      repeat (2) @(negedge Clk);

      // No neighbours, all TC zero
      mLa = 0; mTa = 0;
      for (int i = 0; i < 4; i++) begin mLv[i] = 0; mTv[i] = 0; end
      for (int b = 0; b < 16; b++) tcPlan[b] = 0;
      clearPins();
      for (int b = 0; b < 16; b++) litNc[b] = 0;
      litExp = 0;
      runMb(-1, -1, -1, -1);

      // Both neighbours, left 3 / top 4, decoded TC 2
      mLa = 1; mTa = 1;
      for (int i = 0; i < 4; i++) begin mLv[i] = 3; mTv[i] = 4; end
      for (int b = 0; b < 16; b++) tcPlan[b] = 2;
      clearPins();
      litNc[0] = 4; litNc[1] = 3; litNc[2] = 3; litNc[3] = 2;
      litExp = 2;
      runMb(-1, -1, -1, -1);

      // Top only, col0 = 7, decoded TC 16
      randomizeMb();
      mLa = 0; mTa = 1; mTv[0] = 7;
      for (int b = 0; b < 16; b++) tcPlan[b] = 16;
      litNc[0] = 7; litNc[3] = 16;
      litExp = 16;
      runMb(-1, -1, -1, -1);

      // TotalCoeffIn 20 clamps to 16
      randomizeMb();
      mLa = 0; mTa = 0;
      for (int b = 0; b < 16; b++) tcPlan[b] = 20;
      litNc[0] = 0; litNc[1] = 16;
      litExp = 16;
      runMb(-1, -1, -1, -1);

      // Watchdog abort on block 5, with an ignored MbStart during block 2
      randomizeMb();
      runMb(5, 2, -1, -1);

      // BlockDone in IDLE is ignored
      @(negedge Clk);
      mbIf.BlockDone    = 1'b1;
      mbIf.TotalCoeffIn = TC_W'(9);
      @(negedge Clk);
      mbIf.BlockDone = 1'b0;
      check("idle_blockdone_busy", 32'(mbIf.Busy), 32'd0);
      check("idle_blockdone_enable", 32'(mbIf.CavlcEnable), 32'd0);
      @(negedge Clk);
      check("idle_blockdone_settled", 32'(mbIf.Busy), 32'd0);

      // BlockDone on the watchdog's final cycle, MbStart during DONE ignored
      randomizeMb();
      runMb(-1, 16, -1, TIMEOUT - 1);

      // Asynchronous reset during block 7, then a clean macroblock
      randomizeMb();
      runMb(-1, -1, 7, -1);
      @(negedge Clk);
      randomizeMb();
      mLa = 0; mTa = 0;
      litNc[0] = 0;
      runMb(-1, -1, -1, -1);

      for (int n = 0; n < 4; n++) begin
         randomizeMb();
         runMb(-1, -1, -1, -1);
      end

      repeat (2) @(negedge Clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL global_timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cavlc_mb_scheduler.md
Name: cavlc_mb_scheduler

Overview:
Macroblock-level controller for the CAVLC residual decoder. It sequences the 16 luma 4x4 blocks of one macroblock in H.264 block-scan order and computes the predicted nC for each block from the TotalCoeff of its left and top neighbours. It drives the decoder's Enable and nC, captures TotalCoeffOut on BlockDone, and exports the macroblock's right-column and bottom-row TotalCoeff for neighbouring macroblocks. It sits above the CAVLC top level, between the slice/MB parser and the decoder.

Parameters:
TC_W, 5, width of TotalCoeff and nC values
TIMEOUT, 1024, maximum cycles in RUN per block before abort; 0 disables the watchdog

Ports:
Clk  in  1  clock
nReset  in  1  asynchronous reset, active low
MbStart  in  1  one-cycle pulse: start a macroblock; sampled only in IDLE
LeftAvail  in  1  left macroblock available; sampled on MbStart
TopAvail  in  1  top macroblock available; sampled on MbStart
LeftTotalCoeff  in  4*TC_W  left MB right-column TC, row r at bits [r*TC_W +: TC_W]; sampled on MbStart
TopTotalCoeff  in  4*TC_W  top MB bottom-row TC, column c at bits [c*TC_W +: TC_W]; sampled on MbStart
BlockDone  in  1  decoder block complete, one-cycle pulse
TotalCoeffIn  in  TC_W  decoder TotalCoeffOut, valid with BlockDone
CavlcEnable  out  1  decoder enable, level
nC  out  TC_W  predicted nC, registered
BlkIdx  out  4  current block index, 0..15
Busy  out  1  high from the cycle after MbStart through the DONE state
MbDone  out  1  one-cycle pulse at end of macroblock
Error  out  1  sticky watchdog abort flag; cleared on the next accepted MbStart
RightColTC  out  4*TC_W  this MB column x=3 TC, rows 0..3
BottomRowTC  out  4*TC_W  this MB row y=3 TC, columns 0..3

Behaviour:
- Reset: all outputs 0; state IDLE; internal TC array (16 x TC_W) cleared. An nReset assertion mid-macroblock aborts immediately; the decoder sees CavlcEnable=0 asynchronously.
- Block geometry: x = {BlkIdx[2], BlkIdx[0]}, y = {BlkIdx[3], BlkIdx[1]}.
- Neighbour A (left) is internal TC[x-1,y] if x>0, otherwise LeftTotalCoeff row y, and is available only if LeftAvail.
- Neighbour B (top) is internal TC[x,y-1] if y>0, otherwise TopTotalCoeff column x, and is available only if TopAvail.
- Internal neighbours are always available because scan order guarantees they are already decoded.
- nC rule:
  - both neighbours available: (nA+nB+1)>>1, computed in TC_W+1 bits then truncated; the maximum result is 16.
  - only one available: that neighbour's value.
  - neither available: 0.
- FSM:
  - IDLE: on MbStart, latch the availability flags and neighbour vectors, set BlkIdx=0, clear Error, go to CALC.
  - CALC (1 cycle): register nC for BlkIdx, go to RUN.
  - RUN: CavlcEnable=1 with nC and BlkIdx held stable. On BlockDone, write min(TotalCoeffIn,16) to TC[BlkIdx] and go to STORE. If the watchdog hits TIMEOUT cycles, set Error and go to DONE.
  - STORE (1 cycle, CavlcEnable=0): if BlkIdx==15 go to DONE; otherwise BlkIdx+1, then CALC.
  - DONE (1 cycle): MbDone=1, update RightColTC/BottomRowTC from the TC array, go to IDLE.
- Watchdog: counter clears on entering RUN and increments each RUN cycle; the abort occurs when count==TIMEOUT-1 and BlockDone is low. BlockDone on that same cycle wins.
- On a timeout abort, blocks not yet decoded keep TC 0 in the exported vectors.
- Latency:
  - MbStart at cycle t gives CavlcEnable high at t+2.
  - BlockDone at t gives CavlcEnable low at t+1 and high again at t+3 (2-cycle gap).
  - BlockDone for block 15 at t gives MbDone at t+2.
- Ignored events: BlockDone outside RUN; MbStart outside IDLE, including the DONE cycle.
- RightColTC and BottomRowTC hold their values from MbDone until the next DONE.
- CavlcEnable falls in the cycle after BlockDone, so a decoder that holds BlockDone for more than one cycle is not double-counted.

Test Plan:
- No neighbours, decoder returns TC=0 for all blocks -> nC=0 on all 16 blocks, BlkIdx 0..15 in order, MbDone once, Right/Bottom vectors all 0, Error=0.
- LeftAvail=1, TopAvail=1, Left rows all 3, Top cols all 4, all decoded TC=2 -> blk0 nC=(3+4+1)>>1=4, blk1 nC=(2+4+1)>>1=3, blk2 nC=(3+2+1)>>1=3, blk3 nC=2.
- LeftAvail=0, TopAvail=1, Top col0=7 -> blk0 nC=7. Decoded TC=16 everywhere -> blk3 nC=16 and exported TCs are 16. TotalCoeffIn=20 -> stored 16.
- TIMEOUT=8, no BlockDone for blk5 -> CavlcEnable drops after 8 RUN cycles, Error=1, MbDone pulses, blocks 5..15 export 0. The next MbStart clears Error.
- MbStart pulsed during RUN and BlockDone pulsed in IDLE -> no state change. BlockDone on the watchdog's final cycle -> the block is accepted, Error=0.
- nReset asserted during block 7 RUN -> CavlcEnable=0 immediately, all outputs 0. After release, MbStart runs a full macroblock from blk0 with the TC array cleared.
